// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t    : FSM encoding (idle / port granted)
//   rr_pick_t      : result of a round-robin search (found flag + index)
//   rr_pick()      : round-robin priority search over up to RR_MAX_REQ requesters
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;

    // Widest requester vector the helper function handles.
    localparam int RR_MAX_REQ = 8;
    localparam int RR_IDX_W   = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Search starts one past the previous owner and wraps, so the previous
    // owner has the lowest priority. Only the low num_req bits of valid_vec
    // take part.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid_vec,
        input logic [RR_IDX_W-1:0]   last_owner,
        input int                    num_req
    );
        rr_pick_t res;
        int       cand;
        res  = '0;
        cand = 0;
        for (int k = 1; k <= num_req; k++) begin
            cand = (int'(last_owner) + k) % num_req;
            if (!res.found && valid_vec[RR_IDX_W'(cand)]) begin
                res.found = 1'b1;
                res.idx   = RR_IDX_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin selector.
//   valid_vec  : in,  NUM_REQ   requesters wanting the port
//   last_owner : in,  ID_W      index of the most recent owner
//   found      : out, 1         at least one requester is valid
//   winner     : out, ID_W      selected requester (0 when none found)
module rr_arbiter_core
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_vec,
    input  logic [ID_W-1:0]    last_owner,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    rr_pick_t pick;

    assign pick  = rr_pick(RR_MAX_REQ'(valid_vec), RR_IDX_W'(last_owner), NUM_REQ);
    assign found = pick.found;

    // Narrow the package-wide index down to this instance's id width.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick.idx == RR_IDX_W'(i)) begin
                winner = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NUM_REQ valid/ready producers using
// round-robin arbitration with a burst lock of up to MAX_BURST words.
//   clk          : in,  1               clock, all state on posedge
//   rst          : in,  1               asynchronous reset, active low
//   req_valid    : in,  NUM_REQ         per-requester word valid
//   req_data     : in,  NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//   req_ready    : out, NUM_REQ         per-requester accept
//   fifo_full    : in,  1               FIFO full flag
//   fifo_wr_en   : out, 1               FIFO write enable
//   fifo_data_in : out, DATA_W          FIFO write data
//   grant_valid  : out, 1               a requester owns the port
//   grant_id     : out, ID_W            current owner index
//   wr_total     : out, CNT_W           words written, wraps
//
// state     | meaning
// ----------+--------------------------------------------------------
// ARB_IDLE  | no owner; picks the next valid requester, no data moves
// ARB_GRANT | grant_id owns the port; words pass while FIFO not full
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    parameter  int CNT_W     = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic [CNT_W-1:0]          wr_total
);

    localparam int BURST_W = 4;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_t         state, state_nxt;
    logic [ID_W-1:0]    grant_id_nxt;
    logic               grant_valid_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_nxt;
    logic [ID_W-1:0]    last_owner, last_nxt;
    logic [CNT_W-1:0]   total_nxt;

    logic               arb_found;
    logic [ID_W-1:0]    arb_winner;
    logic               owner_valid;
    logic [DATA_W-1:0]  owner_data;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid_vec  (req_valid),
        .last_owner (last_owner),
        .found      (arb_found),
        .winner     (arb_winner)
    );

    assign owner_valid = req_valid[grant_id];
    assign owner_data  = req_data[grant_id*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            burst_cnt   <= '0;
            last_owner  <= ID_W'(NUM_REQ - 1);
            wr_total    <= '0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_id_nxt;
            grant_valid <= grant_valid_nxt;
            burst_cnt   <= burst_nxt;
            last_owner  <= last_nxt;
            wr_total    <= total_nxt;
        end
    end

    // Port outputs are decoded from the registered state only, so an
    // asynchronous reset removes every write/ready strobe immediately.
    always_comb begin
        state_nxt       = state;
        grant_id_nxt    = grant_id;
        grant_valid_nxt = grant_valid;
        burst_nxt       = burst_cnt;
        last_nxt        = last_owner;
        total_nxt       = wr_total;
        req_ready       = '0;
        fifo_wr_en      = 1'b0;
        fifo_data_in    = '0;

        case (state)
            ARB_IDLE: begin
                if (arb_found) begin
                    state_nxt       = ARB_GRANT;
                    grant_id_nxt    = arb_winner;
                    grant_valid_nxt = 1'b1;
                    burst_nxt       = '0;
                end
            end
            ARB_GRANT: begin
                req_ready[grant_id] = !fifo_full;
                fifo_wr_en          = owner_valid && !fifo_full;
                fifo_data_in        = owner_data;
                if (fifo_wr_en) begin
                    total_nxt = wr_total + 1'b1;
                    burst_nxt = burst_cnt + 1'b1;
                end
                // A full FIFO alone never releases; the owner keeps the port
                // until it drops valid or finishes its burst.
                if (!owner_valid || (fifo_wr_en && burst_cnt == BURST_LAST)) begin
                    state_nxt       = ARB_IDLE;
                    grant_valid_nxt = 1'b0;
                    last_nxt        = grant_id;
                    burst_nxt       = '0;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] wr_total;

    // Second instance with the longest burst, used only to run the write
    // counter through its wrap point in a reasonable number of cycles.
    logic        w_rst;
    logic [3:0]  w_valid;
    logic [31:0] w_data;
    logic        w_full;
    logic [3:0]  w_ready;
    logic        w_wr_en;
    logic [7:0]  w_data_in;
    logic        w_gv;
    logic [1:0]  w_gid;
    logic [15:0] w_total;

    int n_cmp;
    int n_err;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .wr_total     (wr_total)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(15), .CNT_W(16)) dut_wrap (
        .clk          (clk),
        .rst          (w_rst),
        .req_valid    (w_valid),
        .req_data     (w_data),
        .req_ready    (w_ready),
        .fifo_full    (w_full),
        .fifo_wr_en   (w_wr_en),
        .fifo_data_in (w_data_in),
        .grant_valid  (w_gv),
        .grant_id     (w_gid),
        .wr_total     (w_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_wr;
        logic [7:0]  e_data;
        logic        e_gv;
        logic        gid_care;
        logic [1:0]  e_gid;
        logic [15:0] e_total;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_ready, input logic e_wr,
                              input logic [7:0] e_data, input logic e_gv, input logic gcare,
                              input logic [1:0] e_gid, input logic [15:0] e_total);
        check({tag, ".req_ready"}, 32'(req_ready), 32'(e_ready));
        check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(e_wr));
        check({tag, ".data_in"}, 32'(fifo_data_in), 32'(e_data));
        check({tag, ".grant_valid"}, 32'(grant_valid), 32'(e_gv));
        if (gcare) check({tag, ".grant_id"}, 32'(grant_id), 32'(e_gid));
        check({tag, ".wr_total"}, 32'(wr_total), 32'(e_total));
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic f);
        req_valid = v;
        req_data  = d;
        fifo_full = f;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        w_rst = 1'b0;
        w_valid = 4'b0000;
        w_data = 32'h0;
        w_full = 1'b0;
        drive(4'b0000, 32'h0, 1'b0);

        //          rst   valid    data          full  ready    wr    data   gv    care  gid    total
        // single requester 1, three words
        vecs[0]  = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 16'd0};
        vecs[1]  = '{1'b1, 4'b0010, 32'h0000A100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 16'd0};
        vecs[2]  = '{1'b1, 4'b0010, 32'h0000A100, 1'b0, 4'b0010, 1'b1, 8'hA1, 1'b1, 1'b1, 2'd1, 16'd0};
        vecs[3]  = '{1'b1, 4'b0010, 32'h0000A200, 1'b0, 4'b0010, 1'b1, 8'hA2, 1'b1, 1'b1, 2'd1, 16'd1};
        vecs[4]  = '{1'b1, 4'b0010, 32'h0000A300, 1'b0, 4'b0010, 1'b1, 8'hA3, 1'b1, 1'b1, 2'd1, 16'd2};
        vecs[5]  = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 4'b0010, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 16'd3};
        vecs[6]  = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd3};
        // burst limit on requester 0, six words
        vecs[7]  = '{1'b1, 4'b0001, 32'h000000B0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd3};
        vecs[8]  = '{1'b1, 4'b0001, 32'h000000B0, 1'b0, 4'b0001, 1'b1, 8'hB0, 1'b1, 1'b1, 2'd0, 16'd3};
        vecs[9]  = '{1'b1, 4'b0001, 32'h000000B1, 1'b0, 4'b0001, 1'b1, 8'hB1, 1'b1, 1'b1, 2'd0, 16'd4};
        vecs[10] = '{1'b1, 4'b0001, 32'h000000B2, 1'b0, 4'b0001, 1'b1, 8'hB2, 1'b1, 1'b1, 2'd0, 16'd5};
        vecs[11] = '{1'b1, 4'b0001, 32'h000000B3, 1'b0, 4'b0001, 1'b1, 8'hB3, 1'b1, 1'b1, 2'd0, 16'd6};
        vecs[12] = '{1'b1, 4'b0001, 32'h000000B4, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd7};
        vecs[13] = '{1'b1, 4'b0001, 32'h000000B4, 1'b0, 4'b0001, 1'b1, 8'hB4, 1'b1, 1'b1, 2'd0, 16'd7};
        vecs[14] = '{1'b1, 4'b0001, 32'h000000B5, 1'b0, 4'b0001, 1'b1, 8'hB5, 1'b1, 1'b1, 2'd0, 16'd8};
        vecs[15] = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 16'd9};
        // reset, then round robin with all four valid, one word per grant
        vecs[16] = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 16'd0};
        vecs[17] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 16'd0};
        vecs[18] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0001, 1'b1, 8'hC0, 1'b1, 1'b1, 2'd0, 16'd0};
        vecs[19] = '{1'b1, 4'b1110, 32'hC3C2C1C0, 1'b0, 4'b0001, 1'b0, 8'hC0, 1'b1, 1'b1, 2'd0, 16'd1};
        vecs[20] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd1};
        vecs[21] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0010, 1'b1, 8'hC1, 1'b1, 1'b1, 2'd1, 16'd1};
        vecs[22] = '{1'b1, 4'b1101, 32'hC3C2C1C0, 1'b0, 4'b0010, 1'b0, 8'hC1, 1'b1, 1'b1, 2'd1, 16'd2};
        vecs[23] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd2};
        vecs[24] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0100, 1'b1, 8'hC2, 1'b1, 1'b1, 2'd2, 16'd2};
        vecs[25] = '{1'b1, 4'b1011, 32'hC3C2C1C0, 1'b0, 4'b0100, 1'b0, 8'hC2, 1'b1, 1'b1, 2'd2, 16'd3};
        vecs[26] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd3};
        vecs[27] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b1000, 1'b1, 8'hC3, 1'b1, 1'b1, 2'd3, 16'd3};
        vecs[28] = '{1'b1, 4'b0111, 32'hC3C2C1C0, 1'b0, 4'b1000, 1'b0, 8'hC3, 1'b1, 1'b1, 2'd3, 16'd4};
        vecs[29] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd4};
        vecs[30] = '{1'b1, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0001, 1'b1, 8'hC0, 1'b1, 1'b1, 2'd0, 16'd4};
        vecs[31] = '{1'b1, 4'b0000, 32'hC3C2C1C0, 1'b0, 4'b0001, 1'b0, 8'hC0, 1'b1, 1'b1, 2'd0, 16'd5};
        vecs[32] = '{1'b1, 4'b0000, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd5};

        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].valid, vecs[i].data, vecs[i].full);
            #1;
            expect_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wr, vecs[i].e_data,
                       vecs[i].e_gv, vecs[i].gid_care, vecs[i].e_gid, vecs[i].e_total);
            next_cycle();
        end

        // Back-pressure: requester 2 stalls three cycles after its first word.
        drive(4'b0100, 32'h00D00000, 1'b0); #1;
        expect_out("bp_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd5);
        next_cycle();
        #1;
        expect_out("bp_w0", 4'b0100, 1'b1, 8'hD0, 1'b1, 1'b1, 2'd2, 16'd5);
        next_cycle();
        for (int s = 0; s < 3; s++) begin
            drive(4'b0100, 32'h00D10000, 1'b1); #1;
            expect_out($sformatf("bp_stall%0d", s), 4'b0000, 1'b0, 8'hD1, 1'b1, 1'b1, 2'd2, 16'd6);
            next_cycle();
        end
        drive(4'b0100, 32'h00D10000, 1'b0); #1;
        expect_out("bp_w1", 4'b0100, 1'b1, 8'hD1, 1'b1, 1'b1, 2'd2, 16'd6);
        next_cycle();
        drive(4'b0100, 32'h00D20000, 1'b0); #1;
        expect_out("bp_w2", 4'b0100, 1'b1, 8'hD2, 1'b1, 1'b1, 2'd2, 16'd7);
        next_cycle();
        // Still owned here: a burst count that moved during the stall would
        // have released one word early.
        drive(4'b0100, 32'h00D30000, 1'b0); #1;
        expect_out("bp_w3", 4'b0100, 1'b1, 8'hD3, 1'b1, 1'b1, 2'd2, 16'd8);
        next_cycle();
        drive(4'b0000, 32'h0, 1'b0); #1;
        expect_out("bp_release", 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd9);
        next_cycle();

        // Asynchronous reset while requester 1 is two words into a burst.
        drive(4'b0010, 32'h00005500, 1'b0); #1;
        expect_out("ar_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd9);
        next_cycle();
        #1; expect_out("ar_w0", 4'b0010, 1'b1, 8'h55, 1'b1, 1'b1, 2'd1, 16'd9);
        next_cycle();
        #1; expect_out("ar_w1", 4'b0010, 1'b1, 8'h55, 1'b1, 1'b1, 2'd1, 16'd10);
        next_cycle();
        #1; expect_out("ar_w2", 4'b0010, 1'b1, 8'h55, 1'b1, 1'b1, 2'd1, 16'd11);
        #1; rst = 1'b0;
        #1; expect_out("ar_drop", 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 16'd0);
        next_cycle();
        #1; expect_out("ar_hold", 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 16'd0);
        rst = 1'b1;
        drive(4'b1111, 32'hC3C2C1C0, 1'b0);
        #1; expect_out("ar_rel", 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd0);
        next_cycle();
        #1; expect_out("ar_first", 4'b0001, 1'b1, 8'hC0, 1'b1, 1'b1, 2'd0, 16'd0);
        drive(4'b0000, 32'h0, 1'b0);
        next_cycle();

        // Counter wrap on the long-burst instance.
        w_rst = 1'b1;
        w_valid = 4'b0001;
        w_data = 32'h00000077;
        for (int c = 0; c < 80000 && w_total !== 16'hFFFF; c++) @(negedge clk);
        check("wrap_ffff", 32'(w_total), 32'h0000FFFF);
        for (int c = 0; c < 20 && w_total === 16'hFFFF; c++) @(negedge clk);
        check("wrap_0000", 32'(w_total), 32'h00000000);
        for (int c = 0; c < 20 && w_total === 16'h0000; c++) @(negedge clk);
        check("wrap_0001", 32'(w_total), 32'h00000001);
        w_valid = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single 8-bit FIFO write port (wr_en/data_in, with back-pressure from full) between NUM_REQ independent producers. Each producer uses a valid/ready handshake. Arbitration is round-robin with a bounded burst lock, so one requester can push up to MAX_BURST words back-to-back. The block sits between the producer agents and the FIFO write side; the FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, FIFO data width
MAX_BURST, 4, max words accepted from one owner per grant (1..15)
CNT_W, 16, width of total-write counter
ID_W, $clog2(NUM_REQ), width of grant_id (derived, not overridable)

Ports:
clk  input  1  single clock, all state on posedge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*DATA_W  packed words, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept
fifo_full  input  1  FIFO full flag
fifo_wr_en  output  1  FIFO write enable
fifo_data_in  output  DATA_W  FIFO write data
grant_valid  output  1  a requester currently owns the port
grant_id  output  ID_W  current owner index
wr_total  output  CNT_W  count of words written, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant_id=0, grant_valid=0, burst_cnt=0, last_owner=NUM_REQ-1, wr_total=0. All outputs low, including req_ready and fifo_wr_en. Reset asserted mid-burst aborts immediately; no partial write issues after the reset edge.
- FSM states: IDLE and GRANT.
- IDLE, any req_valid=1:
  - Search begins at (last_owner+1) mod NUM_REQ and wraps; the first set index wins.
  - Next edge registers grant_id=winner and grant_valid=1, clears burst_cnt, and moves to GRANT.
  - Arbitration latency is 1 cycle. No data moves in IDLE.
- IDLE, all req_valid=0: remain in IDLE.
- GRANT, combinational outputs (g = grant_id):
  - req_ready[g] = !fifo_full; all other req_ready = 0.
  - fifo_wr_en = req_valid[g] & !fifo_full.
  - fifo_data_in = req_data[g] when the grant is held, else 0.
- Transfer = fifo_wr_en. On each transfer: burst_cnt++ and wr_total++ (wrapping).
- GRANT release (next edge: state=IDLE, grant_valid=0, last_owner=g, burst_cnt=0):
  - (a) req_valid[g]=0 while granted, regardless of fifo_full; or
  - (b) a transfer occurs with burst_cnt == MAX_BURST-1.
- After a release, IDLE re-arbitrates, so there is a 1-cycle bubble between owners.
- fifo_full=1 in GRANT: stall. Grant is held, burst_cnt frozen, no write. The producer must hold valid/data stable.
- Non-owner valids are ignored until a release. Round-robin guarantees every valid requester is served within NUM_REQ grants.
- Handshake rule: a producer may change its data only after a cycle with valid&ready=1.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_GRANT};
  - localparam defaults NUM_REQ_DEF=4, MAX_BURST_DEF=4;
  - a function rr_pick(valid_vec, last_owner) returning the index and a found flag.
- One sub-module fits naturally: rr_arbiter_core. It is purely combinational round-robin priority selection from valid_vec and last_owner. The top holds the FSM, burst counter, wr_total and the output mux.

Test Plan:
- Single requester: req_valid=4'b0010, data 0xA1,0xA2,0xA3, full=0 -> grant_id=1 one cycle later; three consecutive fifo_wr_en pulses carrying 0xA1..0xA3; release when valid drops; wr_total=3.
- Burst limit: req 0 holds valid with 6 words, MAX_BURST=4 -> 4 writes, release, 1 idle cycle, re-grant to req 0 (only valid), 2 more writes; wr_total=6.
- Round-robin fairness: all 4 valid continuously, each with 1 word per grant -> grant order 0,1,2,3,0; no requester granted twice before the others.
- Full back-pressure: req 2 granted, fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 throughout; grant_id stays 2 and burst_cnt is frozen; writes resume with the same data word on full deassert.
- Async reset mid-burst: drive rst=0 between clock edges during a GRANT with burst_cnt=2 -> all outputs drop immediately; after release the first grant goes to requester 0; wr_total=0.
- Counter wrap: preload by running 65535 writes, then 2 more -> wr_total reads 0xFFFF then 0x0000 then 0x0001.
